cache_ctrl_nway: RTL and testbench

Parametrised control FSM for an N-way set-associative, write-back, write-allocate cache in the cache hierarchy. It sits between the CPU-side request port and the next memory level. It drives the way-indexed data, tag and dirty arrays of the cache datapath, and it owns victim selection, tree pseudo-LRU update and hit/miss performance counters. On a dirty miss, writeback of the victim always finishes before the line fill starts. After every fill the FSM replays the lookup, so write-merge logic exists only on the hit path.

---
 rtl/cache_ctrl_nway_if.sv | 27 ++
 rtl/cache_ctrl_nway.sv | 189 ++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_nway_if.sv
// ============================================================================
// cache_ctrl_nway_if : upstream request / downstream memory handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface cache_ctrl_nway_if;
    logic upstream_read;
    logic upstream_write;
    logic upstream_resp;
    logic downstream_read;
    logic downstream_write;
    logic downstream_resp;

    // master: the cache controller; slave: the CPU port and memory around it
    modport master (
        input  upstream_read, upstream_write, downstream_resp,
        output upstream_resp, downstream_read, downstream_write
    );
    modport slave (
        output upstream_read, upstream_write, downstream_resp,
        input  upstream_resp, downstream_read, downstream_write
    );
endinterface

`default_nettype wire

// File: rtl/cache_ctrl_nway.sv
// ============================================================================
// cache_ctrl_nway : N-way write-back / write-allocate cache control FSM with
//                   tree pseudo-LRU and saturating hit/miss counters
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module cache_ctrl_nway #(
    parameter int  WAYS  = 4,
    parameter int  CNT_W = 32,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  wire                clk,
    input  wire                rst_n,
    cache_ctrl_nway_if.master  bus,
    input  wire  [WAYS-1:0]    hit_vec,
    input  wire  [WAYS-1:0]    valid_vec,
    input  wire  [WAYS-1:0]    dirty_vec,
    input  wire  [WAYS-2:0]    plru_in,
    output logic [WAYS-2:0]    plru_out,
    output logic               ld_plru,
    output logic [WAY_W-1:0]   way_sel,
    output logic               data_load_en,
    output logic               data_sel,
    output logic               tag_load_en,
    output logic               dirty_load_en,
    output logic               new_dirty,
    output logic               downstream_address_sel,
    input  wire                clear_counters,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOOKUP    = 2'd1,
        S_WRITEBACK = 2'd2,
        S_FILL      = 2'd3
    } state_t;

    state_t           r_state;
    logic [WAY_W-1:0] r_victim;
    logic             r_replay;

    logic             w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic [WAY_W-1:0] w_free_way;
    logic [WAY_W-1:0] w_lru_way;
    logic [WAY_W-1:0] w_victim;
    logic             w_victim_dirty;
    logic [WAYS-1:0]  w_is_vic;
    logic [WAYS-2:0]  w_plru_upd;
    logic             w_hit_inc;
    logic             w_miss_inc;

    function automatic logic [WAY_W-1:0] f_first_set(input logic [WAYS-1:0] v);
        f_first_set = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) f_first_set = WAY_W'(i);
        end
    endfunction

    // A way is the PLRU victim when every node on its path points toward it.
    for (genvar v = 0; v < WAYS; v++) begin : g_vic_way
        logic [WAY_W-1:0] w_lvl_ok;
        for (genvar l = 0; l < WAY_W; l++) begin : g_vic_lvl
            localparam int   NODE = (1 << l) - 1 + (v >> (WAY_W - l));
            localparam logic DIR  = 1'((v >> (WAY_W - 1 - l)) & 1);
            assign w_lvl_ok[l] = (plru_in[NODE] == DIR);
        end
        assign w_is_vic[v] = &w_lvl_ok;
    end

    // Nodes on the hit way's path point away from it; others pass through.
    for (genvar n = 0; n < WAYS - 1; n++) begin : g_plru_node
        localparam int LVL = $clog2(n + 2) - 1;
        localparam int POS = n - ((1 << LVL) - 1);
        assign w_plru_upd[n] = ((w_hit_way >> (WAY_W - LVL)) == WAY_W'(POS)) ?
                               ~w_hit_way[WAY_W-1-LVL] : plru_in[n];
    end

    assign w_hit          = |hit_vec;
    assign w_hit_way      = f_first_set(hit_vec);
    assign w_free_way     = f_first_set(~valid_vec);
    assign w_lru_way      = f_first_set(w_is_vic);
    assign w_victim       = (&valid_vec) ? w_lru_way : w_free_way;
    assign w_victim_dirty = valid_vec[w_victim] & dirty_vec[w_victim];
    assign w_hit_inc      = (r_state == S_LOOKUP) && w_hit && !r_replay;
    assign w_miss_inc     = (r_state == S_LOOKUP) && !w_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_victim   <= '0;
            r_replay   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.upstream_read || bus.upstream_write) begin
                        r_state  <= S_LOOKUP;
                        r_replay <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_victim <= w_victim;
                        r_state  <= w_victim_dirty ? S_WRITEBACK : S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    if (bus.downstream_resp) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (bus.downstream_resp) begin
                        r_state  <= S_LOOKUP;
                        r_replay <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (clear_counters) begin
                hit_count  <= '0;
                miss_count <= '0;
            end else begin
                if (w_hit_inc && hit_count != c_CNT_MAX)
                    hit_count <= hit_count + 1'b1;
                if (w_miss_inc && miss_count != c_CNT_MAX)
                    miss_count <= miss_count + 1'b1;
            end
        end
    end

    always_comb begin
        bus.upstream_resp      = 1'b0;
        bus.downstream_read    = 1'b0;
        bus.downstream_write   = 1'b0;
        plru_out               = '0;
        ld_plru                = 1'b0;
        way_sel                = '0;
        data_load_en           = 1'b0;
        data_sel               = 1'b0;
        tag_load_en            = 1'b0;
        dirty_load_en          = 1'b0;
        new_dirty              = 1'b0;
        downstream_address_sel = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                if (w_hit) begin
                    way_sel           = w_hit_way;
                    bus.upstream_resp = 1'b1;
                    ld_plru           = 1'b1;
                    plru_out          = w_plru_upd;
                    if (bus.upstream_write) begin
                        data_load_en  = 1'b1;
                        dirty_load_en = 1'b1;
                        new_dirty     = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.downstream_write   = 1'b1;
                downstream_address_sel = 1'b1;
                way_sel                = r_victim;
            end
            S_FILL: begin
                bus.downstream_read = 1'b1;
                way_sel             = r_victim;
                if (bus.downstream_resp) begin
                    data_load_en  = 1'b1;
                    data_sel      = 1'b1;
                    tag_load_en   = 1'b1;
                    dirty_load_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_nway.sv
// ============================================================================
// tb_cache_ctrl_nway : directed bench for cache_ctrl_nway (WAYS=4, CNT_W=4)
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_ctrl_nway;

    localparam int WAYS  = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WAYS-1:0]  hit_vec, valid_vec, dirty_vec;
    logic [WAYS-2:0]  plru_in, plru_out;
    logic             ld_plru;
    logic [1:0]       way_sel;
    logic             data_load_en, data_sel, tag_load_en, dirty_load_en, new_dirty;
    logic             downstream_address_sel, clear_counters;
    logic [CNT_W-1:0] hit_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;

    cache_ctrl_nway_if bus ();

    cache_ctrl_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .bus                    (bus),
        .hit_vec                (hit_vec),
        .valid_vec              (valid_vec),
        .dirty_vec              (dirty_vec),
        .plru_in                (plru_in),
        .plru_out               (plru_out),
        .ld_plru                (ld_plru),
        .way_sel                (way_sel),
        .data_load_en           (data_load_en),
        .data_sel               (data_sel),
        .tag_load_en            (tag_load_en),
        .dirty_load_en          (dirty_load_en),
        .new_dirty              (new_dirty),
        .downstream_address_sel (downstream_address_sel),
        .clear_counters         (clear_counters),
        .hit_count              (hit_count),
        .miss_count             (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Concatenation of every control output, for "all outputs zero" checks.
    function automatic logic [31:0] all_outs();
        return {bus.upstream_resp, bus.downstream_read, bus.downstream_write, plru_out,
                ld_plru, way_sel, data_load_en, data_sel, tag_load_en, dirty_load_en,
                new_dirty, downstream_address_sel, hit_count, miss_count};
    endfunction

    initial begin
        rst_n = 1'b0; hit_vec = '0; valid_vec = '0; dirty_vec = '0; plru_in = '0;
        clear_counters = 1'b0;
        bus.upstream_read = 1'b0; bus.upstream_write = 1'b0; bus.downstream_resp = 1'b0;
        step(); step();
        check_val("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;

        // Stray downstream_resp in IDLE is ignored
        bus.downstream_resp = 1'b1;
        step();
        check_val("idle_resp_ignored", all_outs(), 32'h0);
        bus.downstream_resp = 1'b0;

        // Read hit, way 2, plru 000 -> root 0, node2 1
        valid_vec = 4'b1111; hit_vec = 4'b0100; plru_in = 3'b000; bus.upstream_read = 1'b1;
        #1 check_val("idle_no_resp", bus.upstream_resp, 1'b0);
        step();
        check_val("rd_hit_resp", bus.upstream_resp, 1'b1);
        check_val("rd_hit_way", way_sel, 2'd2);
        check_val("rd_hit_ldplru", ld_plru, 1'b1);
        check_val("rd_hit_plru", plru_out, 3'b100);
        check_val("rd_hit_noload", data_load_en, 1'b0);
        step();
        bus.upstream_read = 1'b0;
        check_val("rd_hit_cnt", hit_count, 4'd1);
        check_val("rd_hit_idle", bus.upstream_resp, 1'b0);

        // Write hit, way 0, plru 100 -> 111
        hit_vec = 4'b0001; plru_in = 3'b100; bus.upstream_write = 1'b1;
        step();
        check_val("wr_hit_ctrl", {data_load_en, data_sel, dirty_load_en, new_dirty, tag_load_en}, 5'b10110);
        check_val("wr_hit_way", way_sel, 2'd0);
        check_val("wr_hit_ds", {bus.downstream_read, bus.downstream_write}, 2'b00);
        check_val("wr_hit_plru", plru_out, 3'b111);
        step();
        bus.upstream_write = 1'b0;
        check_val("wr_hit_cnt", hit_count, 4'd2);

        // Multi-hit: lowest index wins; way 1 from 000 -> 001
        hit_vec = 4'b1010; plru_in = 3'b000; bus.upstream_read = 1'b1;
        step();
        check_val("multi_hit_way", way_sel, 2'd1);
        check_val("multi_hit_plru", plru_out, 3'b001);
        step();
        bus.upstream_read = 1'b0;

        // Clean miss: way 2 invalid (its dirty bit must be ignored)
        hit_vec = 4'b0000; valid_vec = 4'b1011; dirty_vec = 4'b1111; bus.upstream_read = 1'b1;
        step();
        check_val("miss_lookup_resp", bus.upstream_resp, 1'b0);
        check_val("miss_lookup_ds", {bus.downstream_read, bus.downstream_write}, 2'b00);
        step();
        check_val("miss_cnt1", miss_count, 4'd1);
        for (int i = 0; i < 3; i++) begin
            check_val("fill_hold", {bus.downstream_read, bus.downstream_write, way_sel, data_load_en}, 5'b10100);
            step();
        end
        bus.downstream_resp = 1'b1;
        #1 check_val("fill_load", {data_load_en, data_sel, tag_load_en, dirty_load_en, new_dirty}, 5'b11110);
        check_val("fill_way", way_sel, 2'd2);
        step();
        bus.downstream_resp = 1'b0; hit_vec = 4'b0100; valid_vec = 4'b1111;
        #1 check_val("replay_resp", bus.upstream_resp, 1'b1);
        check_val("replay_way", way_sel, 2'd2);
        step();
        bus.upstream_read = 1'b0;
        check_val("replay_no_hitcnt", hit_count, 4'd3);
        check_val("miss_cnt_after", miss_count, 4'd1);

        // Dirty miss: plru 101 -> victim way 3, which is dirty
        hit_vec = 4'b0000; valid_vec = 4'b1111; dirty_vec = 4'b1000; plru_in = 3'b101;
        bus.upstream_read = 1'b1;
        step();
        step();
        check_val("miss_cnt2", miss_count, 4'd2);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) bus.downstream_resp = 1'b1;
            #1 check_val("wb_hold", {bus.downstream_write, bus.downstream_read, downstream_address_sel, way_sel}, 5'b10111);
            step();
        end
        bus.downstream_resp = 1'b0;
        #1 check_val("wb_to_fill", {bus.downstream_write, bus.downstream_read, downstream_address_sel, way_sel}, 5'b01011);
        bus.downstream_resp = 1'b1;
        #1 check_val("wb_fill_tag", tag_load_en, 1'b1);
        step();
        bus.downstream_resp = 1'b0; hit_vec = 4'b1000;
        #1 check_val("wb_replay_resp", bus.upstream_resp, 1'b1);
        check_val("wb_replay_plru", plru_out, 3'b000);
        step();
        bus.upstream_read = 1'b0;

        // Reset in the middle of FILL (victim 0 = lowest invalid)
        hit_vec = 4'b0000; valid_vec = 4'b1110; dirty_vec = 4'b0000; bus.upstream_read = 1'b1;
        step();
        step();
        check_val("pre_rst_fill", {bus.downstream_read, way_sel}, 3'b100);
        rst_n = 1'b0;
        step();
        check_val("rst_fill_outs", all_outs(), 32'h0);
        rst_n = 1'b1; hit_vec = 4'b0001; valid_vec = 4'b1111; plru_in = 3'b000;
        step();
        check_val("post_rst_resp", bus.upstream_resp, 1'b1);
        step();
        check_val("post_rst_cnt", hit_count, 4'd1);

        // Request held: 16 more back-to-back hits saturate at 15
        for (int i = 0; i < 16; i++) begin
            check_val("b2b_resp", bus.upstream_resp, 1'b0);
            step();
            step();
        end
        check_val("hit_sat", hit_count, 4'd15);
        step();
        clear_counters = 1'b1;
        #1 check_val("clr_lookup_resp", bus.upstream_resp, 1'b1);
        step();
        clear_counters = 1'b0;
        check_val("clr_wins", {hit_count, miss_count}, 8'h00);
        step();
        step();
        bus.upstream_read = 1'b0;
        check_val("after_clr_cnt", hit_count, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
